// File: rtl/dram_pkg.sv
// Shared widths and the FIFO entry layout for the sampler-to-DRAM packing path.
// Width helpers clamp to one bit so single-lane or single-word configurations still elaborate.
package dram_pkg;

   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_SAMPLE_WIDTH = 32;
   localparam int DEF_MEM_IF_WIDTH = 128;
   localparam int DEF_ADX_WIDTH    = 27;
   localparam int DEF_FIFO_DEPTH   = 16;
   localparam int DEF_REGION_WORDS = 1024;
   localparam int DEF_PACK         = DEF_MEM_IF_WIDTH / DEF_SAMPLE_WIDTH;

   localparam int PACK_W     = clog2_min1(DEF_PACK);
   localparam int FIFO_PTR_W = clog2_min1(DEF_FIFO_DEPTH);
   localparam int WORD_IDX_W = clog2_min1(DEF_REGION_WORDS);

   typedef struct packed {
      logic [DEF_MEM_IF_WIDTH-1:0] data;
      logic [DEF_ADX_WIDTH-1:0]    adx;
      logic [DEF_PACK-1:0]         lane_mask;
   } dram_word_t;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; the head is visible on rd_data while !empty.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo_fwft #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [PTR_W:0]   count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign empty   = (count == '0);
   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign do_rd   = rd_en && !empty;
   // A full FIFO still accepts a write when the head leaves on the same edge.
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_wr && !do_rd)      count <= count + (PTR_W+1)'(1);
         else if (!do_wr && do_rd) count <= count - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/dram_burst_packer.sv
// Packs samples into memory words, buffers them in a FWFT FIFO and stamps each word with a
// wrapping ring-buffer address; words arriving at a full FIFO are dropped and counted.
module dram_burst_packer
   import dram_pkg::*;
#(
   parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
   parameter int MEM_IF_WIDTH = DEF_MEM_IF_WIDTH,
   parameter int ADX_WIDTH    = DEF_ADX_WIDTH,
   parameter int ADX_STEP     = 8,
   parameter int BASE_ADX     = 0,
   parameter int REGION_WORDS = DEF_REGION_WORDS,
   parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH,
   localparam int PACK = MEM_IF_WIDTH / SAMPLE_WIDTH
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         sample_we,
   input  logic [SAMPLE_WIDTH-1:0]      sample_data,
   input  logic                         flush,
   input  logic                         adx_restart,
   output logic                         mem_wr_req,
   input  logic                         mem_wr_allowed,
   output logic [MEM_IF_WIDTH-1:0]      mem_wr_data,
   output logic [ADX_WIDTH-1:0]         mem_wr_adx,
   output logic [PACK-1:0]              mem_wr_lane_mask,
   output logic                         overflow,
   output logic [15:0]                  drop_count,
   output logic [$clog2(FIFO_DEPTH):0]  fill_level,
   output logic                         idle
);

   localparam int LANE_W = clog2_min1(PACK);
   localparam int IDX_W  = clog2_min1(REGION_WORDS);

   typedef struct packed {
      logic [MEM_IF_WIDTH-1:0] data;
      logic [ADX_WIDTH-1:0]    adx;
      logic [PACK-1:0]         lane_mask;
   } entry_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   logic [LANE_W-1:0]       lane;
   logic [LANE_W:0]         filled;
   logic [MEM_IF_WIDTH-1:0] acc;
   logic [MEM_IF_WIDTH-1:0] acc_next;
   logic [MEM_IF_WIDTH-1:0] word_p0;
   logic [PACK-1:0]         mask_p0;
   logic                    push_p0;
   logic [MEM_IF_WIDTH-1:0] data_p1;
   logic [PACK-1:0]         mask_p1;
   logic                    vld_p1;

   logic [IDX_W-1:0]        word_index;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    pop;
   logic                    push_ok;
   logic                    drop;
   entry_t                  wr_entry;
   entry_t                  head;

   // The current sample lands first, so a sample+flush pair sees the updated fill count.
   always_comb begin
      acc_next = acc;
      word_p0  = '0;
      mask_p0  = '0;
      if (sample_we) acc_next[int'(lane)*SAMPLE_WIDTH +: SAMPLE_WIDTH] = sample_data;
      filled  = {1'b0, lane} + {{LANE_W{1'b0}}, sample_we};
      push_p0 = (filled == (LANE_W+1)'(PACK)) || (flush && (filled != '0));
      for (int k = 0; k < PACK; k++) begin
         mask_p0[k] = (k < int'(filled));
         if (mask_p0[k]) word_p0[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = acc_next[k*SAMPLE_WIDTH +: SAMPLE_WIDTH];
      end
   end

   // p0 -> p1: completed or flushed word is registered here and pushed on the next edge
   always_ff @(posedge clk) begin
      if (!resetn) begin
         lane   <= '0;
         acc    <= '0;
         vld_p1 <= 1'b0;
      end else begin
         acc    <= acc_next;
         vld_p1 <= push_p0;
         if (push_p0)        lane <= '0;
         else if (sample_we) lane <= lane + LANE_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_p0) begin
         data_p1 <= word_p0;
         mask_p1 <= mask_p0;
      end
   end

   // p1 -> FIFO: address is taken from word_index at the moment the push is accepted
   assign pop     = !fifo_empty && mem_wr_allowed;
   assign push_ok = vld_p1 && (!fifo_full || pop);
   assign drop    = vld_p1 && fifo_full && !pop;

   assign wr_entry.data      = data_p1;
   assign wr_entry.adx       = ADX_WIDTH'(BASE_ADX) + ADX_WIDTH'(word_index) * ADX_WIDTH'(ADX_STEP);
   assign wr_entry.lane_mask = mask_p1;

   // Dropped words leave word_index untouched so software sees the address gap.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         word_index <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (adx_restart)  word_index <= '0;
         else if (push_ok) word_index <= (word_index == IDX_W'(REGION_WORDS-1)) ? '0 : word_index + IDX_W'(1);
         if (drop) begin
            overflow   <= 1'b1;
            drop_count <= sat_inc16(drop_count);
         end
      end
   end

   sync_fifo_fwft #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .wr_en   (push_ok),
      .wr_data (wr_entry),
      .rd_en   (pop),
      .rd_data (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fill_level)
   );

   assign mem_wr_req       = !fifo_empty;
   assign mem_wr_data      = head.data;
   assign mem_wr_adx       = head.adx;
   assign mem_wr_lane_mask = head.lane_mask;
   assign idle             = fifo_empty && (lane == '0) && !vld_p1;

endmodule

// File: tb/tb_dram_burst_packer.sv
// Bench for dram_burst_packer: a queue-level model checked every cycle against a default
// instance and a REGION_WORDS=4 instance sharing the same stimulus, plus literal expectations.
module tb_dram_burst_packer;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         sample_we = 1'b0;
   logic [31:0]  sample_data = '0;
   logic         flush = 1'b0;
   logic         adx_restart = 1'b0;
   logic         mem_wr_allowed = 1'b1;

   logic         req_a, req_b;
   logic [127:0] data_a, data_b;
   logic [26:0]  adx_a, adx_b;
   logic [3:0]   mask_a, mask_b;
   logic         ovf_a, ovf_b;
   logic [15:0]  drop_a, drop_b;
   logic [4:0]   fill_a, fill_b;
   logic         idle_a, idle_b;

   always #5 clk = ~clk;

   dram_burst_packer dut (
      .clk(clk), .resetn(resetn), .sample_we(sample_we), .sample_data(sample_data),
      .flush(flush), .adx_restart(adx_restart), .mem_wr_req(req_a),
      .mem_wr_allowed(mem_wr_allowed), .mem_wr_data(data_a), .mem_wr_adx(adx_a),
      .mem_wr_lane_mask(mask_a), .overflow(ovf_a), .drop_count(drop_a),
      .fill_level(fill_a), .idle(idle_a)
   );

   dram_burst_packer #(.REGION_WORDS(4)) dut_wrap (
      .clk(clk), .resetn(resetn), .sample_we(sample_we), .sample_data(sample_data),
      .flush(flush), .adx_restart(adx_restart), .mem_wr_req(req_b),
      .mem_wr_allowed(mem_wr_allowed), .mem_wr_data(data_b), .mem_wr_adx(adx_b),
      .mem_wr_lane_mask(mask_b), .overflow(ovf_b), .drop_count(drop_b),
      .fill_level(fill_b), .idle(idle_b)
   );

   typedef struct {
      logic [127:0] data;
      logic [3:0]   mask;
      int           idx_a;
      int           idx_b;
   } mword_t;

   typedef struct {
      logic [127:0] data;
      logic [26:0]  adx;
      logic [3:0]   mask;
   } xfer_t;

   mword_t       mq[$];
   xfer_t        log_a[$];
   xfer_t        log_b[$];
   int           wi_a, wi_b, cnt, m_drops;
   logic [31:0]  smp[4];
   logic         pend_v;
   logic [127:0] pend_data;
   logic [3:0]   pend_mask;
   logic         m_ovf;
   bit           model_on = 1'b0;
   int           n_checks = 0;
   int           n_pass = 0;
   int           base;

   function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endfunction

   // Spec-level model: samples gather into a word, the word waits one edge, then joins the FIFO.
   task automatic model_step();
      mword_t e;
      if (!resetn) begin
         mq.delete();
         wi_a = 0; wi_b = 0; cnt = 0; pend_v = 1'b0; m_ovf = 1'b0; m_drops = 0;
      end else begin
         if (mq.size() > 0 && mem_wr_allowed) void'(mq.pop_front());
         if (pend_v) begin
            if (mq.size() < 16) begin
               e.data = pend_data; e.mask = pend_mask; e.idx_a = wi_a; e.idx_b = wi_b;
               mq.push_back(e);
               wi_a = (wi_a + 1) % 1024;
               wi_b = (wi_b + 1) % 4;
            end else begin
               m_ovf = 1'b1;
               if (m_drops < 65535) m_drops++;
            end
         end
         if (adx_restart) begin wi_a = 0; wi_b = 0; end
         pend_v = 1'b0;
         if (sample_we) begin smp[cnt] = sample_data; cnt++; end
         if (cnt == 4 || (flush && cnt > 0)) begin
            pend_data = '0; pend_mask = '0;
            for (int k = 0; k < cnt; k++) begin
               pend_data[k*32 +: 32] = smp[k];
               pend_mask[k] = 1'b1;
            end
            pend_v = 1'b1;
            cnt = 0;
         end
      end
   endtask

   task automatic compare();
      logic m_idle;
      m_idle = (mq.size() == 0) && (cnt == 0) && !pend_v;
      chk("req_a", 128'(req_a), 128'(mq.size() > 0));
      chk("req_b", 128'(req_b), 128'(mq.size() > 0));
      if (mq.size() > 0) begin
         chk("data_a", data_a, mq[0].data);
         chk("data_b", data_b, mq[0].data);
         chk("adx_a", 128'(adx_a), 128'(mq[0].idx_a * 8));
         chk("adx_b", 128'(adx_b), 128'(mq[0].idx_b * 8));
         chk("mask_a", 128'(mask_a), 128'(mq[0].mask));
         chk("mask_b", 128'(mask_b), 128'(mq[0].mask));
      end
      chk("fill_a", 128'(fill_a), 128'(mq.size()));
      chk("fill_b", 128'(fill_b), 128'(mq.size()));
      chk("ovf_a", 128'(ovf_a), 128'(m_ovf));
      chk("drop_a", 128'(drop_a), 128'(m_drops));
      chk("drop_b", 128'(drop_b), 128'(m_drops));
      chk("idle_a", 128'(idle_a), 128'(m_idle));
      chk("idle_b", 128'(idle_b), 128'(m_idle));
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (req_a && mem_wr_allowed) log_a.push_back('{data_a, adx_a, mask_a});
      if (req_b && mem_wr_allowed) log_b.push_back('{data_b, adx_b, mask_b});
      if (model_on) compare();
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) tick();
   endtask

   task automatic send(input logic [31:0] s);
      sample_we = 1'b1;
      sample_data = s;
      tick();
      sample_we = 1'b0;
   endtask

   task automatic reset_outputs(input string tag);
      chk({tag, "_req"},  128'(req_a),  128'(0));
      chk({tag, "_idle"}, 128'(idle_a), 128'(1));
      chk({tag, "_fill"}, 128'(fill_a), 128'(0));
      chk({tag, "_ovf"},  128'(ovf_a),  128'(0));
      chk({tag, "_drop"}, 128'(drop_a), 128'(0));
      chk({tag, "_data"}, data_a, 128'(0));
   endtask

   initial begin
      wait_cycles(3);
      resetn = 1'b1;
      model_on = 1'b1;
      reset_outputs("rst");

      // two full words, push latency
      base = log_a.size();
      for (int i = 1; i <= 4; i++) send(32'(i));
      chk("lat_t", 128'(req_a), 128'(0));
      send(32'd5);
      chk("lat_t1", 128'(req_a), 128'(1));
      for (int i = 6; i <= 8; i++) send(32'(i));
      wait_cycles(4);
      chk("full_cnt", 128'(log_a.size() - base), 128'(2));
      chk("w0_data", log_a[base].data, 128'h00000004_00000003_00000002_00000001);
      chk("w0_adx", 128'(log_a[base].adx), 128'(0));
      chk("w0_mask", 128'(log_a[base].mask), 128'hF);
      chk("w1_data", log_a[base+1].data, 128'h00000008_00000007_00000006_00000005);
      chk("w1_adx", 128'(log_a[base+1].adx), 128'(8));

      // partial flush
      base = log_a.size();
      send(32'hA); send(32'hB); send(32'hC);
      flush = 1'b1; tick(); flush = 1'b0;
      wait_cycles(4);
      chk("part_data", log_a[base].data, 128'h00000000_0000000C_0000000B_0000000A);
      chk("part_mask", 128'(log_a[base].mask), 128'b0111);
      chk("part_adx", 128'(log_a[base].adx), 128'(16));
      chk("part_idle", 128'(idle_a), 128'(1));

      // flush with nothing buffered
      base = log_a.size();
      flush = 1'b1; tick(); flush = 1'b0;
      wait_cycles(3);
      chk("flush0_cnt", 128'(log_a.size() - base), 128'(0));

      // sample completing a word together with flush
      base = log_a.size();
      send(32'h21); send(32'h22); send(32'h23);
      sample_we = 1'b1; sample_data = 32'h24; flush = 1'b1;
      tick();
      sample_we = 1'b0; flush = 1'b0;
      wait_cycles(4);
      chk("sf_cnt", 128'(log_a.size() - base), 128'(1));
      chk("sf_data", log_a[base].data, 128'h00000024_00000023_00000022_00000021);
      chk("sf_mask", 128'(log_a[base].mask), 128'hF);

      // single sample + flush: fifth word, wraps on the small region
      base = log_a.size();
      sample_we = 1'b1; sample_data = 32'h31; flush = 1'b1;
      tick();
      sample_we = 1'b0; flush = 1'b0;
      wait_cycles(4);
      chk("one_data", log_a[base].data, 128'h31);
      chk("one_mask", 128'(log_a[base].mask), 128'h1);
      chk("one_adx_a", 128'(log_a[base].adx), 128'(32));
      chk("wrap_adx3", 128'(log_b[log_b.size()-2].adx), 128'(24));
      chk("wrap_adx4", 128'(log_b[log_b.size()-1].adx), 128'(0));

      // address restart
      adx_restart = 1'b1; tick(); adx_restart = 1'b0;
      for (int i = 0; i < 4; i++) send(32'h41 + 32'(i));
      wait_cycles(4);
      chk("rs_adx_a", 128'(log_a[log_a.size()-1].adx), 128'(0));
      chk("rs_adx_b", 128'(log_b[log_b.size()-1].adx), 128'(0));

      // overflow under full backpressure
      resetn = 1'b0; tick(); resetn = 1'b1;
      mem_wr_allowed = 1'b0;
      for (int i = 0; i < 72; i++) send(32'h1000 + 32'(i));
      wait_cycles(3);
      chk("ov_fill", 128'(fill_a), 128'(16));
      chk("ov_flag", 128'(ovf_a), 128'(1));
      chk("ov_drops", 128'(drop_a), 128'(2));
      base = log_a.size();
      mem_wr_allowed = 1'b1;
      wait_cycles(20);
      chk("drain_cnt", 128'(log_a.size() - base), 128'(16));
      for (int i = 0; i < 16; i++) chk("drain_adx", 128'(log_a[base+i].adx), 128'(i * 8));

      // random backpressure
      base = log_a.size();
      for (int i = 0; i < 40; i++) begin
         mem_wr_allowed = 1'($urandom_range(0, 1));
         send(32'h100 + 32'(i));
      end
      mem_wr_allowed = 1'b1;
      wait_cycles(20);
      chk("bp_cnt", 128'(log_a.size() - base), 128'(10));
      chk("bp_first", log_a[base].data, 128'h00000103_00000102_00000101_00000100);
      chk("bp_last", log_a[base+9].data, 128'h00000127_00000126_00000125_00000124);

      // reset mid-stream
      send(32'h51); send(32'h52);
      resetn = 1'b0; tick(); resetn = 1'b1;
      reset_outputs("mid");
      base = log_a.size();
      for (int i = 0; i < 4; i++) send(32'h61 + 32'(i));
      wait_cycles(4);
      chk("mid_cnt", 128'(log_a.size() - base), 128'(1));
      chk("mid_data", log_a[base].data, 128'h00000064_00000063_00000062_00000061);
      chk("mid_adx", 128'(log_a[base].adx), 128'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dram_burst_packer.md
Name: dram_burst_packer

Overview:
Parametrised successor to the sampler-to-DRAM packer. It packs SAMPLE_WIDTH samples into MEM_IF_WIDTH memory words, buffers completed words in an internal first-word-fall-through (FWFT) FIFO and generates wrapping ring-buffer addresses. It adds several features the first-generation packer lacked:
- explicit flush of a partial word, with a lane-valid mask
- backpressure tolerance through the FIFO
- overflow detection
Sits between the sampler/trigger logic and the DDR memory interface write port.

Parameters:
SAMPLE_WIDTH, 32, bits per sample; MEM_IF_WIDTH must be an integer multiple of it
MEM_IF_WIDTH, 128, memory data width; PACK = MEM_IF_WIDTH/SAMPLE_WIDTH lanes
ADX_WIDTH, 27, memory address width
ADX_STEP, 8, address increment per memory word
BASE_ADX, 0, first address of the capture region
REGION_WORDS, 1024, words in the region before the address wraps to BASE_ADX
FIFO_DEPTH, 16, buffered memory words; power of two, at least 2

Ports:
clk  in  1  clock
resetn  in  1  reset, synchronous, active-low
sample_we  in  1  sample_data valid this cycle
sample_data  in  SAMPLE_WIDTH  sample
flush  in  1  pulse: emit the partial word, if any
adx_restart  in  1  pulse: next pushed word gets address BASE_ADX
mem_wr_req  out  1  FIFO head valid
mem_wr_allowed  in  1  memory accepts the head this cycle
mem_wr_data  out  MEM_IF_WIDTH  head data
mem_wr_adx  out  ADX_WIDTH  head address
mem_wr_lane_mask  out  PACK  head lane-valid bits; bit k covers lane k
overflow  out  1  sticky: a word was dropped
drop_count  out  16  dropped words, saturating at 16'hFFFF
fill_level  out  clog2(FIFO_DEPTH)+1  FIFO occupancy
idle  out  1  FIFO empty, lane index 0, no push pending

Behaviour:
- Reset values: all outputs 0, except idle which is 1. Lane index, word index, accumulator and FIFO are cleared. A reset mid-operation discards all data.
- Lane packing: sample n of a word occupies bits [n*SAMPLE_WIDTH +: SAMPLE_WIDTH]. Each sample_we advances the lane index.
- Full word: when the sample in lane PACK-1 arrives, the word with mask all-ones is pushed at the next clock edge and the lane index returns to 0. Back-to-back sample_we is sustained indefinitely with no bubbles.
- Flush with a partial word (lane index > 0): push the accumulated lanes with mask bits set for the filled lanes only; unfilled lanes read as zero.
- Flush with lane index 0: no push.
- sample_we and flush in the same cycle: the sample is included first, then the flush applies. If that sample completes the word, exactly one full word is pushed.
- Address: word_index starts at 0. Each pushed word gets address BASE_ADX + word_index*ADX_STEP. word_index then increments and wraps to 0 after REGION_WORDS-1.
- adx_restart sets word_index to 0 for the next push. If it coincides with a push, that push uses the old index and the following word uses BASE_ADX.
- Addresses and word_index advance only on successful pushes.
- Push latency: the sample completing a word, or the flush, at edge t makes mem_wr_req high after edge t+1 when the FIFO was empty.
- Memory handshake: a transfer occurs on a cycle where mem_wr_req && mem_wr_allowed. mem_wr_data, mem_wr_adx and mem_wr_lane_mask stay stable while mem_wr_req && !mem_wr_allowed. mem_wr_allowed is ignored while mem_wr_req is low.
- FIFO full, push attempted: the new word is dropped, overflow is set and drop_count is incremented. word_index does not advance, so the address gap is visible to software.
- FIFO full with a simultaneous pop and push: the push succeeds and no drop occurs.
- FIFO empty with a simultaneous push and pop: the pop cannot occur because mem_wr_req is low; the push becomes visible the next cycle.
- overflow and drop_count clear only on reset.
- fill_level counts words currently in the FIFO, 0 to FIFO_DEPTH.

Decomposition:
- Package dram_pkg holds:
  - clog2-based width constants for PACK, the FIFO pointer width and word_index
  - a packed struct typedef {data, adx, lane_mask} for FIFO entries
- One sub-module: sync_fifo_fwft, parametrised by width and depth, with full, empty and count outputs. It is used here and is reusable elsewhere in the memory interface.
- Packing, address generation and overflow logic stay in dram_burst_packer.

Test Plan:
- Full words at default parameters: 8 consecutive samples 0x1..0x8 with mem_wr_allowed=1 -> two transfers.
  - Word 0: data 0x00000004_00000003_00000002_00000001, adx 0, mask 4'hF.
  - Word 1: adx 8.
- Partial flush: 3 samples 0xA,0xB,0xC, then flush -> data 0x00000000_0000000C_0000000B_0000000A, mask 4'b0111; idle=1 after the transfer.
- Address wrap: REGION_WORDS=4, push 5 words -> adx 0,8,16,24,0. adx_restart after word 2 -> the next word is at adx 0.
- Overflow: mem_wr_allowed=0, 18 full words pushed -> fill_level=16, overflow=1, drop_count=2.
  - Releasing backpressure then drains 16 words with adx 0..120 in order.
- Backpressure stability: toggle mem_wr_allowed randomly -> head data, address and mask stay unchanged while req && !allowed; no word is lost or duplicated versus a scoreboard.
- Reset mid-stream: resetn low for 1 cycle after 2 samples -> all outputs at reset values. The next 4 samples form a word at adx 0.
